// File: rtl/game_controller_mp_if.sv
// Handshake bundle between the key decoder / game core and game_controller_mp.
// The master side drives the press pulses, move_tick and game_over; the controller is the slave.
interface game_controller_mp_if #(
  parameter int N_PLAYERS = 2,
  parameter int CW        = 2
);
  logic [4*N_PLAYERS-1:0] dir_press;
  logic                   space_press;
  logic                   r_press;
  logic                   move_tick;
  logic                   game_over;
  logic [3*N_PLAYERS-1:0] dir;
  logic [2:0]             game_state;
  logic                   game_run;
  logic [CW-1:0]          countdown;
  logic                   game_reset_pulse;
  logic [N_PLAYERS-1:0]   q_overflow;

  modport master (
    output dir_press, space_press, r_press, move_tick, game_over,
    input  dir, game_state, game_run, countdown, game_reset_pulse, q_overflow
  );

  modport slave (
    input  dir_press, space_press, r_press, move_tick, game_over,
    output dir, game_state, game_run, countdown, game_reset_pulse, q_overflow
  );
endinterface

// File: rtl/game_controller_mp.sv
// Game state FSM (STOPPED/COUNTDOWN/RUNNING/PAUSED/OVER) plus one direction queue per player,
// each queue drained one entry per RUNNING move_tick.
module game_controller_mp #(
  parameter int N_PLAYERS     = 2,
  parameter int QDEPTH        = 4,
  parameter int START_TICKS   = 3,
  parameter bit ALLOW_REVERSE = 1'b0,
  localparam int CW = (START_TICKS > 0) ? $clog2(START_TICKS + 1) : 1
) (
  input logic                 clk,
  input logic                 rst,
  game_controller_mp_if.slave bus
);

  localparam int CNTW = $clog2(QDEPTH + 1);

  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_DOWN  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  typedef enum logic [2:0] {
    ST_STOPPED   = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUNNING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  // One code per cycle even when several keys arrive together: up > down > left > right.
  function automatic logic [2:0] press_code(input logic [3:0] keys);
    if (keys[0])      return D_UP;
    else if (keys[1]) return D_DOWN;
    else if (keys[2]) return D_LEFT;
    else if (keys[3]) return D_RIGHT;
    else              return D_NONE;
  endfunction

  function automatic logic [2:0] opposite(input logic [2:0] code);
    case (code)
      D_UP:    return D_DOWN;
      D_DOWN:  return D_UP;
      D_LEFT:  return D_RIGHT;
      D_RIGHT: return D_LEFT;
      default: return D_NONE;
    endcase
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] countdown, countdown_n;
  logic          pulse, pulse_n;
  logic          run;

  logic [2:0]      q      [N_PLAYERS][QDEPTH];
  logic [2:0]      q_n    [N_PLAYERS][QDEPTH];
  logic [CNTW-1:0] cnt    [N_PLAYERS];
  logic [CNTW-1:0] cnt_n  [N_PLAYERS];
  logic [2:0]      dir_r  [N_PLAYERS];
  logic [2:0]      dir_n  [N_PLAYERS];
  logic [N_PLAYERS-1:0] ovf, ovf_n;

  always_comb begin
    state_n     = state;
    countdown_n = '0;
    pulse_n     = 1'b0;
    case (state)
      ST_STOPPED: begin
        if (bus.r_press) begin
          pulse_n = 1'b1;
        end else if (bus.space_press) begin
          if (START_TICKS == 0) begin
            state_n = ST_RUNNING;
          end else begin
            state_n     = ST_COUNTDOWN;
            countdown_n = CW'(START_TICKS);
          end
        end
      end
      ST_COUNTDOWN: begin
        if (bus.r_press) begin
          pulse_n = 1'b1;
          state_n = ST_STOPPED;
        end else if (bus.space_press) begin
          state_n = ST_STOPPED;
        end else if (bus.move_tick) begin
          if (countdown == CW'(1)) state_n = ST_RUNNING;
          else                     countdown_n = countdown - CW'(1);
        end else begin
          countdown_n = countdown;
        end
      end
      ST_RUNNING: begin
        if (bus.game_over)        state_n = ST_OVER;
        else if (bus.space_press) state_n = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (bus.r_press) begin
          pulse_n = 1'b1;
          state_n = ST_STOPPED;
        end else if (bus.space_press) begin
          state_n = ST_RUNNING;
        end
      end
      ST_OVER: begin
        if (bus.r_press) begin
          pulse_n = 1'b1;
          state_n = ST_STOPPED;
        end
      end
      default: state_n = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_STOPPED;
      countdown <= '0;
      pulse     <= 1'b1;
      run       <= 1'b0;
    end else begin
      state     <= state_n;
      countdown <= countdown_n;
      pulse     <= pulse_n;
      run       <= (state_n == ST_RUNNING);
    end
  end

  // Queues are shift registers with the head at index 0; a push lands at the first free slot
  // after any pop of this cycle has been applied.
  always_comb begin
    logic [2:0] code;
    logic [2:0] last;
    logic       accept;
    logic       pop;
    logic       full;
    logic       take;
    logic       push;
    int         wpos;
    accept = ((state == ST_COUNTDOWN) || (state == ST_RUNNING)) && !pulse;
    ovf_n  = ovf;
    for (int p = 0; p < N_PLAYERS; p++) begin
      q_n[p]   = q[p];
      cnt_n[p] = cnt[p];
      dir_n[p] = dir_r[p];
      code     = press_code(bus.dir_press[4*p +: 4]);
      last     = dir_r[p];
      for (int i = 0; i < QDEPTH; i++) begin
        if (i == int'(cnt[p]) - 1) last = q[p][i];
      end
      pop  = (state == ST_RUNNING) && bus.move_tick && (cnt[p] != '0);
      full = (int'(cnt[p]) == QDEPTH);
      take = accept && (code != D_NONE) && (code != last) &&
             (ALLOW_REVERSE || (code != opposite(last)));
      push = take && (!full || pop);
      if (take && full && !pop) ovf_n[p] = 1'b1;
      if (pop) begin
        dir_n[p] = q[p][0];
        for (int i = 0; i < QDEPTH - 1; i++) q_n[p][i] = q[p][i+1];
      end
      wpos = int'(cnt[p]) - (pop ? 1 : 0);
      if (push) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (i == wpos) q_n[p][i] = code;
        end
      end
      cnt_n[p] = cnt[p] + CNTW'(push) - CNTW'(pop);
      if (pulse) begin
        cnt_n[p] = '0;
        dir_n[p] = D_NONE;
        ovf_n[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
        cnt[p]   <= '0;
        dir_r[p] <= D_NONE;
      end
    end else begin
      ovf <= ovf_n;
      for (int p = 0; p < N_PLAYERS; p++) begin
        cnt[p]   <= cnt_n[p];
        dir_r[p] <= dir_n[p];
      end
    end
  end

  // Entry storage is qualified by cnt, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < N_PLAYERS; p++) begin
      for (int i = 0; i < QDEPTH; i++) q[p][i] <= q_n[p][i];
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_dir
    assign bus.dir[3*p +: 3] = dir_r[p];
  end

  assign bus.game_state       = state;
  assign bus.game_run         = run;
  assign bus.countdown        = countdown;
  assign bus.game_reset_pulse = pulse;
  assign bus.q_overflow       = ovf;

endmodule

// File: tb/tb_game_controller_mp.sv
// Directed scenarios followed by random traffic, every cycle compared against a queue-based model.
module tb_game_controller_mp;

  localparam int NP = 2;
  localparam int QD = 4;
  localparam int ST = 3;
  localparam bit AR = 1'b0;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_controller_mp_if #(.N_PLAYERS(NP), .CW(CW)) bus ();

  game_controller_mp #(
    .N_PLAYERS(NP), .QDEPTH(QD), .START_TICKS(ST), .ALLOW_REVERSE(AR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int m_state, m_cd, m_pulse, m_run;
  int m_dir [NP];
  int m_ovf [NP];
  int mq    [NP][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int key_code(input logic [3:0] k);
    if (k[0]) return 1;
    if (k[1]) return 2;
    if (k[2]) return 3;
    if (k[3]) return 4;
    return 0;
  endfunction

  function automatic int opp(input int c);
    case (c)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cd = 0; m_pulse = 1; m_run = 0;
    for (int p = 0; p < NP; p++) begin
      m_dir[p] = 0; m_ovf[p] = 0; mq[p].delete();
    end
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    int ns, ncd, npulse, code, r;
    bit popped, do_push;
    for (int p = 0; p < NP; p++) begin
      if (m_pulse != 0) begin
        mq[p].delete(); m_dir[p] = 0; m_ovf[p] = 0;
      end else begin
        popped  = (m_state == 2) && bus.move_tick && (mq[p].size() > 0);
        do_push = 1'b0;
        code    = key_code(bus.dir_press[4*p +: 4]);
        if ((m_state == 1 || m_state == 2) && code != 0) begin
          r = (mq[p].size() > 0) ? mq[p][$] : m_dir[p];
          if (code != r && (AR || code != opp(r))) begin
            if (mq[p].size() < QD || popped) do_push = 1'b1;
            else m_ovf[p] = 1;
          end
        end
        if (popped)  m_dir[p] = mq[p].pop_front();
        if (do_push) mq[p].push_back(code);
      end
    end
    ns = m_state; ncd = 0; npulse = 0;
    case (m_state)
      0: if (bus.r_press) npulse = 1;
         else if (bus.space_press) begin
           if (ST == 0) ns = 2;
           else begin ns = 1; ncd = ST; end
         end
      1: if (bus.r_press) begin npulse = 1; ns = 0; end
         else if (bus.space_press) ns = 0;
         else if (bus.move_tick) begin
           ncd = m_cd - 1;
           if (ncd == 0) ns = 2;
         end else ncd = m_cd;
      2: if (bus.game_over) ns = 4;
         else if (bus.space_press) ns = 3;
      3: if (bus.r_press) begin npulse = 1; ns = 0; end
         else if (bus.space_press) ns = 2;
      4: if (bus.r_press) begin npulse = 1; ns = 0; end
      default: ns = 0;
    endcase
    m_state = ns; m_cd = ncd; m_pulse = npulse; m_run = (ns == 2) ? 1 : 0;
  endtask

  task automatic check_all();
    logic [3*NP-1:0] ed;
    logic [NP-1:0]   eo;
    for (int p = 0; p < NP; p++) begin
      ed[3*p +: 3] = 3'(m_dir[p]);
      eo[p]        = (m_ovf[p] != 0);
    end
    chk("m_state", 32'(bus.game_state), 32'(m_state));
    chk("m_run", 32'(bus.game_run), 32'(m_run));
    chk("m_countdown", 32'(bus.countdown), 32'(m_cd));
    chk("m_pulse", 32'(bus.game_reset_pulse), 32'(m_pulse));
    chk("m_dir", 32'(bus.dir), 32'(ed));
    chk("m_q_overflow", 32'(bus.q_overflow), 32'(eo));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic step(input logic [4*NP-1:0] dp, input bit sp, input bit rp, input bit tk);
    bus.dir_press = dp; bus.space_press = sp; bus.r_press = rp; bus.move_tick = tk;
    cycle();
    bus.dir_press = '0; bus.space_press = 1'b0; bus.r_press = 1'b0; bus.move_tick = 1'b0;
  endtask

  initial begin
    bus.dir_press = '0; bus.space_press = 1'b0; bus.r_press = 1'b0;
    bus.move_tick = 1'b0; bus.game_over = 1'b0;

    // 1: reset and the single init pulse
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("t1_pulse_in_rst", 32'(bus.game_reset_pulse), 32'd1);
    rst = 1'b0;
    cycle();
    chk("t1_pulse_after", 32'(bus.game_reset_pulse), 32'd0);
    chk("t1_state", 32'(bus.game_state), 32'd0);
    chk("t1_dir", 32'(bus.dir), 32'd0);

    // 2: countdown 3,2,1 then RUNNING
    step('0, 1, 0, 0);
    chk("t2_cd3", 32'(bus.countdown), 32'd3);
    chk("t2_state_cd", 32'(bus.game_state), 32'd1);
    step('0, 0, 0, 1);
    chk("t2_cd2", 32'(bus.countdown), 32'd2);
    step('0, 0, 0, 1);
    chk("t2_cd1", 32'(bus.countdown), 32'd1);
    step('0, 0, 0, 1);
    chk("t2_running", 32'(bus.game_state), 32'd2);
    chk("t2_run", 32'(bus.game_run), 32'd1);
    chk("t2_cd0", 32'(bus.countdown), 32'd0);

    // 3: reverse rejection and queue ordering for player 0
    step(8'h08, 0, 0, 0);
    step('0, 0, 0, 1);
    chk("t3_dir_right", 32'(bus.dir[2:0]), 32'd4);
    step(8'h04, 0, 0, 0);
    step('0, 0, 0, 1);
    chk("t3_left_dropped", 32'(bus.dir[2:0]), 32'd4);
    step(8'h01, 0, 0, 0);
    step(8'h02, 0, 0, 0);
    step(8'h04, 0, 0, 0);
    step('0, 0, 0, 1);
    chk("t3_dir_up", 32'(bus.dir[2:0]), 32'd1);
    step('0, 0, 0, 1);
    chk("t3_dir_left", 32'(bus.dir[2:0]), 32'd3);

    // 4: overflow on player 0, full+press+tick on player 1
    step(8'h01, 0, 0, 0);
    step(8'h08, 0, 0, 0);
    step(8'h01, 0, 0, 0);
    step(8'h08, 0, 0, 0);
    chk("t4_no_ovf_yet", 32'(bus.q_overflow), 32'd0);
    step(8'h01, 0, 0, 0);
    chk("t4_ovf0", 32'(bus.q_overflow), 32'd1);
    step(8'h10, 0, 0, 0);
    step(8'h80, 0, 0, 0);
    step(8'h10, 0, 0, 0);
    step(8'h80, 0, 0, 0);
    step(8'h20, 0, 0, 1);
    chk("t4_full_push_no_ovf", 32'(bus.q_overflow), 32'd1);
    chk("t4_dir1_up", 32'(bus.dir[5:3]), 32'd1);
    repeat (4) step('0, 0, 0, 1);
    chk("t4_dir1_down_last", 32'(bus.dir[5:3]), 32'd2);

    // 5: game_over beats space, OVER ignores space, r_press flushes
    bus.game_over = 1'b1;
    step('0, 1, 0, 0);
    chk("t5_over", 32'(bus.game_state), 32'd4);
    step('0, 1, 0, 0);
    chk("t5_space_ignored", 32'(bus.game_state), 32'd4);
    bus.game_over = 1'b0;
    step('0, 0, 1, 0);
    chk("t5_stopped", 32'(bus.game_state), 32'd0);
    chk("t5_pulse", 32'(bus.game_reset_pulse), 32'd1);
    step('0, 0, 0, 0);
    chk("t5_dir_cleared", 32'(bus.dir), 32'd0);
    chk("t5_ovf_cleared", 32'(bus.q_overflow), 32'd0);

    // 6: PAUSED discards presses; r_press beats space
    step('0, 1, 0, 0);
    repeat (3) step('0, 0, 0, 1);
    step(8'h10, 0, 0, 0);
    step('0, 1, 0, 0);
    chk("t6_paused", 32'(bus.game_state), 32'd3);
    step(8'h20, 0, 0, 0);
    step(8'h40, 0, 0, 0);
    step('0, 1, 0, 0);
    step('0, 0, 0, 1);
    chk("t6_dir1_up", 32'(bus.dir[5:3]), 32'd1);
    step('0, 0, 0, 1);
    chk("t6_paused_press_discarded", 32'(bus.dir[5:3]), 32'd1);
    step('0, 1, 0, 0);
    step('0, 1, 1, 0);
    chk("t6_stopped", 32'(bus.game_state), 32'd0);
    chk("t6_pulse", 32'(bus.game_reset_pulse), 32'd1);
    step('0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4*NP-1:0] dp;
      for (int p = 0; p < NP; p++)
        dp[4*p +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      bus.game_over = ($urandom_range(0, 39) == 0);
      step(dp, ($urandom_range(0, 11) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
